// File: rtl/func_arbiter.sv
// Round-robin arbiter sharing one multi-cycle function unit between N requesters.
// Captures the winner's operands, pulses start, waits on busy and returns the result or a timeout.
module func_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RES_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N-1:0]          req_i,
    input  logic [N*DATA_W-1:0]   a_i,
    input  logic [N*DATA_W-1:0]   b_i,
    output logic [N-1:0]          gnt_o,
    output logic [N-1:0]          done_o,
    output logic [RES_W-1:0]      res_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [DATA_W-1:0]     func_a_o,
    output logic [DATA_W-1:0]     func_b_o,
    output logic                  func_start_o,
    input  logic                  func_busy_i,
    input  logic [RES_W-1:0]      func_res_i
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state, state_next;
    logic [IDX_W-1:0]  owner, ptr, winner;
    logic [N-1:0]      owner_oh;
    logic [WD_W-1:0]   wdog;
    logic              found, take, finish, abort;

    // Search starts just after the last winner so every held request is reached within N ops.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!found && req_i[(32'(ptr) + k) % N]) begin
                winner = IDX_W'((32'(ptr) + k) % N);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            StIdle: begin
                if (found && !func_busy_i) begin
                    take       = 1'b1;
                    state_next = StIssue;
                end
            end
            StIssue: state_next = StWait;
            StWait: begin
                if (!func_busy_i) begin
                    finish     = 1'b1;
                    state_next = StIdle;
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    finish     = 1'b1;
                    abort      = 1'b1;
                    state_next = StIdle;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    assign owner_oh     = N'(1) << owner;
    assign gnt_o        = (state == StIssue) ? owner_oh : '0;
    assign func_start_o = (state == StIssue);
    assign busy_o       = (state != StIdle);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= StIdle;
            owner    <= '0;
            ptr      <= IDX_W'(N - 1);
            wdog     <= '0;
            done_o   <= '0;
            err_o    <= 1'b0;
            res_o    <= '0;
            func_a_o <= '0;
            func_b_o <= '0;
        end else begin
            state  <= state_next;
            done_o <= finish ? owner_oh : '0;
            err_o  <= abort;
            if (take) begin
                owner    <= winner;
                ptr      <= winner;
                func_a_o <= a_i[winner*DATA_W +: DATA_W];
                func_b_o <= b_i[winner*DATA_W +: DATA_W];
            end
            if (state == StIssue) begin
                wdog <= '0;
            end else if (state == StWait && func_busy_i) begin
                wdog <= wdog + 1'b1;
            end
            if (finish) begin
                res_o <= abort ? '0 : func_res_i;
            end
        end
    end

endmodule
